staff_note_ctrl: RTL and testbench
==================================

// Module: staff_note_ctrl
// PURPOSE
//  Sequences the scan-code-to-tone lookup (staff) from a raw PS/2 byte stream.
//  Parses make/break/extended framing, drives scan_code into the lookup, samples the returned 16-bit tone value,
//  and synthesises a square wave via a phase accumulator (NCO). Sits between the PS/2 receiver and the speaker pin.
//  Last-pressed-key priority, monophonic, with a release tail.
// PARAMETERS
//  ACC_W        24     NCO accumulator width; f_out = sound * f_clk / 2^ACC_W
//  REL_CYCLES   50000  clocks the tone continues after the held key's break code (>=1)
//  REL_W        16     release counter width; must hold REL_CYCLES
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous, active-high reset
//  rx_data     in   8   PS/2 byte from receiver
//  rx_valid    in   1   one-cycle strobe, rx_data valid
//  scan_code   out  8   registered code driven into the staff lookup
//  sound       in   16  tone value returned combinationally by the lookup; 16'd1 = unmapped
//  speaker     out  1   square-wave output
//  note_active out  1   high while a key is held and playing (PLAY state)
//  evt_drop    out  1   one-cycle pulse: key event discarded (arrived during LOOKUP)
// BEHAVIOUR
//  Reset (async): scan_code=8'h00, prev_code=8'h00, acc=0, rel_cnt=0, parser=P_IDLE, note FSM=SILENT,
//   speaker=0, note_active=0, evt_drop=0. Reset mid-note silences speaker immediately.
//  Parser (advances only on rx_valid): P_IDLE: F0->P_BRK, E0->P_EXT, else make(code)->P_IDLE.
//   P_BRK: E0 ignored (stay), else break(code)->P_IDLE. P_EXT: F0->P_EXTBRK, else discard->P_IDLE.
//   P_EXTBRK: any byte discarded->P_IDLE. Extended events never reach the note FSM.
//  Note FSM states SILENT, LOOKUP, PLAY, RELEASE:
//   make(c), state SILENT/PLAY/RELEASE, c != scan_code or state != PLAY: prev_code<=scan_code, scan_code<=c,
//    ret_state<=state, ->LOOKUP.
//   make(c) in PLAY with c == scan_code (typematic): no change, no phase reset.
//   LOOKUP (exactly 1 cycle): sound != 1 -> PLAY; sound == 1 -> scan_code<=prev_code, ->ret_state.
//   break(c) in PLAY with c == scan_code: rel_cnt<=REL_CYCLES-1, ->RELEASE. break of other code: ignored.
//   RELEASE: rel_cnt decrements each cycle; at 0 -> SILENT, scan_code<=8'h00 in the same edge.
//   Any completed event during LOOKUP: discarded, evt_drop=1 next cycle; parser state still updates.
//  Latency: make completing at edge n -> scan_code valid after n -> LOOKUP decision at n+1 ->
//   note_active=1 after edge n+1.
//  NCO: in PLAY/RELEASE acc <= acc + {0, sound} (mod 2^ACC_W); in SILENT/LOOKUP acc holds.
//   Switching notes does not reset acc (phase continuous). Entering SILENT clears acc to 0.
//  speaker = acc[ACC_W-1] registered, forced 0 in SILENT; holds last value during LOOKUP.
//  note_active = (state == PLAY). Key switch via LOOKUP drops note_active for 1 cycle.
// TESTING
//  1 Reset, bytes 2B -> scan_code=2B, note_active high 2 edges after strobe, acc steps +565/clk, speaker toggles.
//  2 While playing 2B send 2B x3 (repeat) -> no LOOKUP, acc sequence uninterrupted; then F0 2B -> RELEASE,
//    speaker runs REL_CYCLES clocks, then SILENT, scan_code=00, speaker=0, acc=0.
//  3 Playing 2B, send 1C -> scan_code=1C, step +423, acc not reset; F0 2B -> ignored, still PLAY.
//  4 Playing 34, send unmapped 29 -> LOOKUP, sound=1, scan_code reverts to 34, back to PLAY; from SILENT
//    same -> returns SILENT, scan_code=00.
//  5 E0 2B and E0 F0 2B -> no state change; F0 E0 ... not producing events; bytes 1B then 2B back-to-back
//    (2nd during LOOKUP) -> evt_drop pulse, plays 1B.
//  6 Assert rst mid-RELEASE -> speaker=0, note_active=0, scan_code=00 asynchronously; next make plays normally.

Source files
------------

// File: rtl/staff_note_ctrl.sv
// PS/2 make/break parser driving a scan-code-to-tone lookup, with a phase-continuous
// NCO square-wave synthesiser; monophonic, last-key priority, with a release tail.
module staff_note_ctrl #(
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned REL_CYCLES = 50000,
    parameter int unsigned REL_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  scan_code,
    input  logic [15:0] sound,
    output logic        speaker,
    output logic        note_active,
    output logic        evt_drop
);

    localparam logic [7:0]       BRK_BYTE = 8'hF0;
    localparam logic [7:0]       EXT_BYTE = 8'hE0;
    localparam logic [15:0]      UNMAPPED = 16'd1;
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_CYCLES - 1);

    typedef enum logic [1:0] {P_IDLE, P_BRK, P_EXT, P_EXTBRK} pstate_e;
    typedef enum logic [1:0] {S_SILENT, S_LOOKUP, S_PLAY, S_RELEASE} nstate_e;

    pstate_e          pstate_q, pstate_d;
    nstate_e          state_q, state_d;
    nstate_e          ret_state_q, ret_state_d;
    logic [7:0]       scan_code_q, scan_code_d;
    logic [7:0]       prev_code_q, prev_code_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;
    logic             speaker_q, speaker_d;
    logic             note_active_q, note_active_d;
    logic             evt_drop_q, evt_drop_d;
    logic             make_c, brk_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate_q      <= P_IDLE;
            state_q       <= S_SILENT;
            ret_state_q   <= S_SILENT;
            scan_code_q   <= 8'h00;
            prev_code_q   <= 8'h00;
            acc_q         <= '0;
            rel_cnt_q     <= '0;
            speaker_q     <= 1'b0;
            note_active_q <= 1'b0;
            evt_drop_q    <= 1'b0;
        end else begin
            pstate_q      <= pstate_d;
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            scan_code_q   <= scan_code_d;
            prev_code_q   <= prev_code_d;
            acc_q         <= acc_d;
            rel_cnt_q     <= rel_cnt_d;
            speaker_q     <= speaker_d;
            note_active_q <= note_active_d;
            evt_drop_q    <= evt_drop_d;
        end
    end

    // Byte framing: only plain (non-E0) make/break completions become events.
    always_comb begin
        pstate_d = pstate_q;
        make_c   = 1'b0;
        brk_c    = 1'b0;
        if (rx_valid) begin
            case (pstate_q)
                P_IDLE: begin
                    if (rx_data == BRK_BYTE)      pstate_d = P_BRK;
                    else if (rx_data == EXT_BYTE) pstate_d = P_EXT;
                    else                          make_c   = 1'b1;
                end
                P_BRK: begin
                    if (rx_data != EXT_BYTE) begin
                        brk_c    = 1'b1;
                        pstate_d = P_IDLE;
                    end
                end
                P_EXT:    pstate_d = (rx_data == BRK_BYTE) ? P_EXTBRK : P_IDLE;
                default:  pstate_d = P_IDLE;
            endcase
        end
    end

    // Note sequencing, release countdown and NCO.
    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        scan_code_d = scan_code_q;
        prev_code_d = prev_code_q;
        rel_cnt_d   = rel_cnt_q;
        acc_d       = acc_q;
        evt_drop_d  = 1'b0;

        if (state_q == S_PLAY || state_q == S_RELEASE) begin
            acc_d = acc_q + ACC_W'(sound);
        end

        case (state_q)
            S_LOOKUP: begin
                evt_drop_d = make_c | brk_c;
                if (sound != UNMAPPED) begin
                    state_d = S_PLAY;
                end else begin
                    scan_code_d = prev_code_q;
                    state_d     = ret_state_q;
                end
            end
            default: begin
                if (make_c && (state_q != S_PLAY || rx_data != scan_code_q)) begin
                    prev_code_d = scan_code_q;
                    scan_code_d = rx_data;
                    ret_state_d = state_q;
                    state_d     = S_LOOKUP;
                end else if (brk_c && state_q == S_PLAY && rx_data == scan_code_q) begin
                    rel_cnt_d = REL_LAST;
                    state_d   = S_RELEASE;
                end else if (state_q == S_RELEASE) begin
                    if (rel_cnt_q == '0) begin
                        state_d     = S_SILENT;
                        scan_code_d = 8'h00;
                    end else begin
                        rel_cnt_d = rel_cnt_q - REL_W'(1);
                    end
                end
            end
        endcase

        // Silence always restarts the phase from zero.
        if (state_d == S_SILENT) begin
            acc_d = '0;
        end

        speaker_d     = (state_d == S_SILENT) ? 1'b0 : acc_d[ACC_W-1];
        note_active_d = (state_d == S_PLAY);
    end

    assign scan_code   = scan_code_q;
    assign speaker     = speaker_q;
    assign note_active = note_active_q;
    assign evt_drop    = evt_drop_q;

endmodule

// File: tb/tb_staff_note_ctrl.sv
// Bench for staff_note_ctrl: directed vector table, hand sequences for release/reset
// corners, and random byte traffic against a behavioural key/tone model.
module tb_staff_note_ctrl;

    localparam int unsigned ACC_W      = 12;
    localparam int unsigned REL_CYCLES = 20;
    localparam int unsigned REL_W      = 8;
    localparam int          ACC_MOD    = 1 << ACC_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  scan_code;
    logic [15:0] sound;
    logic        speaker;
    logic        note_active;
    logic        evt_drop;

    int errors = 0;
    int checks = 0;

    staff_note_ctrl #(
        .ACC_W(ACC_W), .REL_CYCLES(REL_CYCLES), .REL_W(REL_W)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .scan_code(scan_code), .sound(sound), .speaker(speaker),
        .note_active(note_active), .evt_drop(evt_drop)
    );

    always #5 clk = ~clk;

    function automatic int lut(input logic [7:0] c);
        case (c)
            8'h2B:   return 565;
            8'h1C:   return 423;
            8'h34:   return 480;
            8'h1B:   return 505;
            8'h23:   return 634;
            default: return 1;
        endcase
    endfunction

    assign sound = 16'(lut(scan_code));

    // Behavioural model: prefix flags, held key, lookup pending, release cycles left.
    bit       m_seen_brk, m_seen_ext;
    bit       m_sounding, m_lookup;
    int       m_rel_left;
    bit       m_ret_snd;
    int       m_ret_rel;
    logic [7:0] m_code, m_prev;
    int       m_acc;
    bit       m_drop;

    task automatic model_reset();
        m_seen_brk = 0; m_seen_ext = 0; m_sounding = 0; m_lookup = 0;
        m_rel_left = 0; m_ret_snd = 0; m_ret_rel = 0;
        m_code = 8'h00; m_prev = 8'h00; m_acc = 0; m_drop = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        bit ev_make = 0;
        bit ev_brk  = 0;
        bit playing;
        if (v) begin
            if (m_seen_ext && m_seen_brk) begin
                m_seen_ext = 0; m_seen_brk = 0;
            end else if (m_seen_ext) begin
                if (d == 8'hF0) m_seen_brk = 1;
                else m_seen_ext = 0;
            end else if (m_seen_brk) begin
                if (d != 8'hE0) begin ev_brk = 1; m_seen_brk = 0; end
            end else if (d == 8'hF0) m_seen_brk = 1;
            else if (d == 8'hE0) m_seen_ext = 1;
            else ev_make = 1;
        end
        m_drop  = 0;
        playing = m_sounding && !m_lookup && m_rel_left == 0;
        if (m_lookup) begin
            m_drop   = ev_make || ev_brk;
            m_lookup = 0;
            if (lut(m_code) != 1) begin
                m_sounding = 1; m_rel_left = 0;
            end else begin
                m_code = m_prev; m_sounding = m_ret_snd; m_rel_left = m_ret_rel;
            end
        end else begin
            if (m_sounding) m_acc = (m_acc + lut(m_code)) % ACC_MOD;
            if (ev_make && !(playing && d == m_code)) begin
                m_ret_snd = m_sounding; m_ret_rel = m_rel_left;
                m_prev = m_code; m_code = d; m_lookup = 1;
            end else if (ev_brk && playing && d == m_code) begin
                m_rel_left = REL_CYCLES;
            end else if (m_sounding && m_rel_left > 0) begin
                m_rel_left--;
                if (m_rel_left == 0) begin
                    m_sounding = 0; m_code = 8'h00; m_acc = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("scan_code", int'(scan_code), int'(m_code));
        chk("note_active", int'(note_active), int'(m_sounding && !m_lookup && m_rel_left == 0));
        chk("evt_drop", int'(evt_drop), int'(m_drop));
        chk("acc", int'(dut.acc_q), m_acc);
        chk("speaker", int'(speaker), (m_acc >> (ACC_W - 1)) & 1);
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model_step(v, d);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] exp_code;
        logic       exp_active;
        logic       exp_drop;
    } vec_t;

    vec_t vecs[20];

    initial begin
        vecs[0]  = '{1'b1, 8'h2B, 8'h2B, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h2B, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h2B, 8'h2B, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h2B, 8'h2B, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h1C, 8'h1C, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h2B, 8'h1C, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 8'hF0, 8'h1C, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h2B, 8'h1C, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h34, 8'h34, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 8'h34, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h29, 8'h29, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 8'h34, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'hE0, 8'h34, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'h2B, 8'h34, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 8'hE0, 8'h34, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 8'hF0, 8'h34, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 8'h34, 8'h34, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 8'hF0, 8'h34, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 8'hE0, 8'h34, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 8'h34, 8'h34, 1'b0, 1'b0};

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        model_reset();
        #12;
        chk("rst_scan_code", int'(scan_code), 0);
        chk("rst_speaker", int'(speaker), 0);
        chk("rst_note_active", int'(note_active), 0);
        chk("rst_evt_drop", int'(evt_drop), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: play, typematic, switch, unmapped revert, extended codes, release.
        for (int i = 0; i < 20; i++) begin
            tick(vecs[i].v, vecs[i].d);
            chk($sformatf("vec%0d_code", i), int'(scan_code), int'(vecs[i].exp_code));
            chk($sformatf("vec%0d_active", i), int'(note_active), int'(vecs[i].exp_active));
            chk($sformatf("vec%0d_drop", i), int'(evt_drop), int'(vecs[i].exp_drop));
        end

        // Release tail lasts exactly REL_CYCLES clocks.
        for (int i = 0; i < REL_CYCLES - 1; i++) tick(1'b0, 8'h00);
        chk("rel_tail_code", int'(scan_code), 8'h34);
        tick(1'b0, 8'h00);
        chk("rel_end_code", int'(scan_code), 0);
        chk("rel_end_speaker", int'(speaker), 0);
        chk("rel_end_acc", int'(dut.acc_q), 0);
        chk("rel_end_active", int'(note_active), 0);

        // Unmapped make from silence returns to silence.
        tick(1'b1, 8'h29);
        chk("sil_unmapped_code", int'(scan_code), 8'h29);
        tick(1'b0, 8'h00);
        chk("sil_revert_code", int'(scan_code), 0);
        chk("sil_revert_active", int'(note_active), 0);

        // Back-to-back makes: second lands in LOOKUP and is dropped.
        tick(1'b1, 8'h1B);
        tick(1'b1, 8'h2B);
        chk("b2b_drop", int'(evt_drop), 1);
        chk("b2b_code", int'(scan_code), 8'h1B);
        tick(1'b0, 8'h00);
        chk("b2b_drop_clear", int'(evt_drop), 0);
        chk("b2b_active", int'(note_active), 1);

        // Reset in the middle of a release tail.
        tick(1'b1, 8'hF0);
        tick(1'b1, 8'h1B);
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h00);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_speaker", int'(speaker), 0);
        chk("arst_active", int'(note_active), 0);
        chk("arst_code", int'(scan_code), 0);
        #1 rst = 1'b0;
        tick(1'b1, 8'h2B);
        tick(1'b0, 8'h00);
        chk("post_rst_active", int'(note_active), 1);
        chk("post_rst_code", int'(scan_code), 8'h2B);

        // Random byte traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic [7:0] d;
            v = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0, 1:    d = 8'hF0;
                2:       d = 8'hE0;
                3:       d = 8'h2B;
                4:       d = 8'h1C;
                5:       d = 8'h34;
                6:       d = 8'h1B;
                7:       d = 8'h23;
                8:       d = 8'h29;
                default: d = 8'($urandom_range(0, 255));
            endcase
            tick(v, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
